// File: rtl/lab8_soc_key_code_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab8_soc_key_code_pkg
// Description : Shared constants for the key-code FIFO Avalon-MM slave:
//               register word offsets and STATUS/CONTROL bit positions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lab8_soc_key_code_pkg;

  // Avalon word offsets
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_LAST    = 2'd3;

  // Bit positions inside STATUS / CONTROL / DATA
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int CTRL_IRQEN_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int DATA_VALID_BIT = 31;

endpackage : lab8_soc_key_code_pkg
`default_nettype wire

// File: rtl/key_code_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : key_code_fifo_core
// Description : Circular FIFO storage for key codes with read/write pointers
//               and an occupancy count. Flush overrides push and pop.
// Ports       : clk, reset_n       - clock, async active-low reset
//               push, pop, flush   - qualified strobes from the top level
//               din                - code to store on push
//               head               - oldest stored code
//               count, full, empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module key_code_fifo_core #(
  parameter  int CODE_W = 16,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);

endmodule : key_code_fifo_core
`default_nettype wire

// File: rtl/lab8_soc_key_code_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lab8_soc_key_code_fifo
// Description : Avalon-MM slave queueing keyboard scan codes for CPU polling,
//               with status, sticky overflow, flush and a level interrupt.
//               out_port mirrors the most recently accepted code.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               address, chipselect, read_n,
//               write_n, writedata, readdata - Avalon-MM slave (0 latency)
//               key_code, key_valid, key_ready - keyboard push handshake
//               out_port                     - last accepted code
//               irq                          - registered level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module lab8_soc_key_code_fifo
  import lab8_soc_key_code_pkg::*;
#(
  parameter  int CODE_W = 16,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [CODE_W-1:0] out_port,
  output logic              irq
);

  logic              w_wr_sel;
  logic              w_rd_sel;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_count;
  logic [CODE_W-1:0] w_head;
  logic [31:0]       w_readdata;
  logic              w_unused;

  logic              r_overflow;
  logic              r_irq_en;
  logic [CODE_W-1:0] r_out_port;
  logic              r_irq;

  assign w_wr_sel = chipselect & ~write_n;
  assign w_rd_sel = chipselect & ~read_n;

  // Flush is a write strobe; it never gets stored.
  assign w_flush  = w_wr_sel & (address == ADDR_CONTROL) & writedata[CTRL_FLUSH_BIT];

  assign key_ready = ~w_full & ~w_flush;
  assign w_push    = key_valid & key_ready;
  assign w_pop     = w_rd_sel & (address == ADDR_DATA) & ~w_empty;

  // A refused code is only an overflow when it was not refused by a flush.
  assign w_ovf_set = key_valid & ~key_ready & ~w_flush;
  assign w_ovf_clr = w_wr_sel & (address == ADDR_STATUS) & writedata[STAT_OVF_BIT];

  assign w_unused  = ^{writedata[31:19], writedata[17:2]};

  key_code_fifo_core #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     (key_code),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
      r_out_port <= '0;
      r_irq      <= 1'b0;
    end else begin
      // Set wins over a simultaneous clear so no overflow event is missed.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_sel && (address == ADDR_CONTROL)) begin
        r_irq_en <= writedata[CTRL_IRQEN_BIT];
      end
      if (w_push) begin
        r_out_port <= key_code;
      end
      // Built from registered state, so irq trails state changes by one edge.
      r_irq <= r_irq_en & (~w_empty | r_overflow);
    end
  end

  always_comb begin
    w_readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) begin
          w_readdata[DATA_VALID_BIT] = 1'b1;
          w_readdata[CODE_W-1:0]     = w_head;
        end
      end
      ADDR_STATUS: begin
        w_readdata[PTR_W:0]        = w_count;
        w_readdata[STAT_EMPTY_BIT] = w_empty;
        w_readdata[STAT_FULL_BIT]  = w_full;
        w_readdata[STAT_OVF_BIT]   = r_overflow;
      end
      ADDR_CONTROL: begin
        w_readdata[CTRL_IRQEN_BIT] = r_irq_en;
      end
      ADDR_LAST: begin
        w_readdata[CODE_W-1:0] = r_out_port;
      end
      default: begin
        w_readdata = '0;
      end
    endcase
  end

  assign readdata = w_readdata;
  assign out_port = r_out_port;
  assign irq      = r_irq;

endmodule : lab8_soc_key_code_fifo
`default_nettype wire

// File: tb/tb_lab8_soc_key_code_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab8_soc_key_code_fifo
// Description : Self-checking bench for the key-code FIFO slave. Expected
//               Avalon read data is queued by the stimulus and compared by a
//               separate monitor whenever a read strobe is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab8_soc_key_code_fifo;

  localparam int CODE_W = 16;
  localparam int DEPTH  = 8;

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_CONTROL = 2'd2;
  localparam logic [1:0] A_LAST    = 2'd3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic [CODE_W-1:0] out_port;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  lab8_soc_key_code_fifo #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .out_port   (out_port),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented read strobe consumes one expectation.
  always @(negedge clk) begin
    if (reset_n && chipselect && !read_n) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL read_unexpected: got 0x%08h, expected no read (t=%0t)", readdata, $time);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  // All tasks start and finish 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [31:0] e);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    exp_q.push_back(e);
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic push_code(input logic [CODE_W-1:0] c);
    key_code  = c;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    key_code   = '0;
    key_valid  = 1'b0;
    #22;
    reset_n = 1'b1;
    tick();

    // 1: reset state
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_out_port", 32'(out_port), 32'h0);
    check("reset_key_ready", 32'(key_ready), 32'h1);
    cpu_read(A_STATUS, 32'h0001_0000);
    cpu_read(A_DATA, 32'h0000_0000);
    cpu_read(A_STATUS, 32'h0001_0000);

    // 2: three codes in, read back in order
    push_code(16'h001C);
    push_code(16'h0032);
    push_code(16'h0023);
    cpu_read(A_STATUS, 32'h0000_0003);
    check("out_port_last", 32'(out_port), 32'h0000_0023);
    cpu_read(A_LAST, 32'h0000_0023);
    cpu_read(A_DATA, 32'h8000_001C);
    cpu_read(A_DATA, 32'h8000_0032);
    cpu_read(A_DATA, 32'h8000_0023);
    cpu_read(A_STATUS, 32'h0001_0000);

    // 3: fill, then a ninth code is refused and flagged
    for (int i = 0; i < DEPTH; i++) push_code(16'h0100 + 16'(i));
    cpu_read(A_STATUS, 32'h0002_0008);
    key_code  = 16'h01FF;
    key_valid = 1'b1;
    #1;
    check("full_key_ready", 32'(key_ready), 32'h0);
    tick();
    key_valid = 1'b0;
    cpu_read(A_STATUS, 32'h0006_0008);
    check("out_port_after_drop", 32'(out_port), 32'h0000_0107);
    cpu_write(A_STATUS, 32'h0004_0000);
    cpu_read(A_STATUS, 32'h0002_0008);

    // 4: pop while full with key_valid held; push lands on the next edge
    address    = A_DATA;
    chipselect = 1'b1;
    read_n     = 1'b0;
    exp_q.push_back(32'h8000_0100);
    key_code   = 16'h01AA;
    key_valid  = 1'b1;
    #1;
    check("popfull_key_ready", 32'(key_ready), 32'h0);
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
    check("after_pop_key_ready", 32'(key_ready), 32'h1);
    tick();
    key_valid = 1'b0;
    // The held cycle while full is a refused push, which marks overflow;
    // clear it so the readback isolates count/full.
    cpu_write(A_STATUS, 32'h0004_0000);
    cpu_read(A_STATUS, 32'h0002_0008);
    for (int i = 1; i < DEPTH; i++) cpu_read(A_DATA, 32'h8000_0100 + 32'(i));
    cpu_read(A_DATA, 32'h8000_01AA);
    cpu_read(A_STATUS, 32'h0001_0000);

    // 5: interrupt timing and flush
    cpu_write(A_CONTROL, 32'h0000_0001);
    tick();
    check("irq_empty", 32'(irq), 32'h0);
    push_code(16'h0055);
    check("irq_push_edge", 32'(irq), 32'h0);
    tick();
    check("irq_rise", 32'(irq), 32'h1);
    cpu_read(A_DATA, 32'h8000_0055);
    check("irq_pop_edge", 32'(irq), 32'h1);
    tick();
    check("irq_fall", 32'(irq), 32'h0);
    push_code(16'h0061);
    push_code(16'h0062);
    address    = A_CONTROL;
    writedata  = 32'h0000_0003;
    chipselect = 1'b1;
    write_n    = 1'b0;
    key_code   = 16'h0077;
    key_valid  = 1'b1;
    #1;
    check("flush_key_ready", 32'(key_ready), 32'h0);
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    key_valid  = 1'b0;
    cpu_read(A_STATUS, 32'h0001_0000);
    check("irq_after_flush", 32'(irq), 32'h0);
    check("out_port_flush", 32'(out_port), 32'h0000_0062);
    cpu_read(A_CONTROL, 32'h0000_0001);

    // 6: asynchronous reset with codes queued
    for (int i = 0; i < 5; i++) push_code(16'h0031 + 16'(i));
    tick();
    check("irq_before_reset", 32'(irq), 32'h1);
    address = A_STATUS;
    #1;
    check("count_before_reset", readdata, 32'h0000_0005);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_status", readdata, 32'h0001_0000);
    check("areset_irq", 32'(irq), 32'h0);
    check("areset_out_port", 32'(out_port), 32'h0);
    check("areset_key_ready", 32'(key_ready), 32'h1);
    #2;
    reset_n = 1'b1;
    tick();
    cpu_read(A_CONTROL, 32'h0000_0000);
    cpu_read(A_DATA, 32'h0000_0000);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lab8_soc_key_code_fifo
`default_nettype wire
